// File: rtl/pmu_seq_ctrl_if.sv
// Handshake/bus bundle between the PMU sequencer and its datapath (SIPO, key store, AES, PISO, scan chain).
interface pmu_seq_ctrl_if #(
  parameter int unsigned INSTR_W = 4
);
  logic               en;
  logic               data_i;
  logic               aes_done;
  logic               sipo_en;
  logic               sipo_send;
  logic [INSTR_W-1:0] instr_o;
  logic               key_write;
  logic               aes_start;
  logic               aes_clr;
  logic               piso_load;
  logic               piso_en;
  logic               sc_en;
  logic               sc_clear;
  logic               busy;
  logic               err;
  logic [2:0]         state_o;

  modport master (
    output en, data_i, aes_done,
    input  sipo_en, sipo_send, instr_o, key_write, aes_start, aes_clr,
           piso_load, piso_en, sc_en, sc_clear, busy, err, state_o
  );

  modport slave (
    input  en, data_i, aes_done,
    output sipo_en, sipo_send, instr_o, key_write, aes_start, aes_clr,
           piso_load, piso_en, sc_en, sc_clear, busy, err, state_o
  );
endinterface

// File: rtl/pmu_seq_ctrl.sv
// PMU sequencer: decodes a serial instruction, steers the payload through SIPO into the key store or
// inverse AES, then shifts the plaintext through the PISO into the scan chain.
module pmu_seq_ctrl #(
  parameter int unsigned BLOCK_W     = 128,
  parameter int unsigned INSTR_W     = 4,
  parameter int unsigned AES_TIMEOUT = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  pmu_seq_ctrl_if.slave        bus
);

  localparam int unsigned CNT_W = $clog2(BLOCK_W + 1);
  localparam int unsigned TMR_W = $clog2(AES_TIMEOUT);

  localparam logic [CNT_W-1:0]   BLOCK_LAST  = CNT_W'(BLOCK_W - 1);
  localparam logic [CNT_W-1:0]   INSTR_LAST  = CNT_W'(INSTR_W - 1);
  localparam logic [TMR_W-1:0]   TMR_LAST    = TMR_W'(AES_TIMEOUT - 1);
  localparam logic [INSTR_W-1:0] OP_LOAD_KEY = INSTR_W'(1);
  localparam logic [INSTR_W-1:0] OP_DECRYPT  = INSTR_W'(2);
  localparam logic [INSTR_W-1:0] OP_CLEAR    = INSTR_W'(3);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_INSTR   = 3'd1,
    S_LOAD    = 3'd2,
    S_DECRYPT = 3'd3,
    S_SHIFT   = 3'd4,
    S_CLEAR   = 3'd5
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [TMR_W-1:0]   tmr_q, tmr_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [INSTR_W-1:0] instr_sh;
  logic               err_q, err_d;
  logic               sipo_send_q, sipo_send_d;
  logic               key_write_q, key_write_d;
  logic               aes_start_q, aes_start_d;
  logic               aes_clr_q, aes_clr_d;
  logic               piso_load_q, piso_load_d;

  assign instr_sh = {instr_q[INSTR_W-2:0], bus.data_i};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      tmr_q       <= '0;
      instr_q     <= '0;
      err_q       <= 1'b0;
      sipo_send_q <= 1'b0;
      key_write_q <= 1'b0;
      aes_start_q <= 1'b0;
      aes_clr_q   <= 1'b0;
      piso_load_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      tmr_q       <= tmr_d;
      instr_q     <= instr_d;
      err_q       <= err_d;
      sipo_send_q <= sipo_send_d;
      key_write_q <= key_write_d;
      aes_start_q <= aes_start_d;
      aes_clr_q   <= aes_clr_d;
      piso_load_q <= piso_load_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    tmr_d       = tmr_q;
    instr_d     = instr_q;
    err_d       = err_q;
    sipo_send_d = 1'b0;
    key_write_d = 1'b0;
    aes_start_d = 1'b0;
    aes_clr_d   = 1'b0;
    piso_load_d = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.en) begin
          instr_d = instr_sh;
          cnt_d   = CNT_W'(1);
          state_d = S_INSTR;
        end
      end
      S_INSTR: begin
        if (bus.en) begin
          instr_d = instr_sh;
          cnt_d   = cnt_q + CNT_W'(1);
          // Decode on the cycle the last opcode bit arrives so the payload may follow back-to-back.
          if (cnt_q == INSTR_LAST) begin
            cnt_d = '0;
            if (instr_sh == OP_LOAD_KEY || instr_sh == OP_DECRYPT) begin
              state_d = S_LOAD;
            end else if (instr_sh == OP_CLEAR) begin
              state_d = S_CLEAR;
            end else begin
              err_d   = 1'b1;
              state_d = S_IDLE;
            end
          end
        end
      end
      S_LOAD: begin
        if (bus.en) begin
          if (cnt_q == BLOCK_LAST) begin
            cnt_d       = '0;
            sipo_send_d = 1'b1;
            if (instr_q == OP_DECRYPT) begin
              aes_start_d = 1'b1;
              tmr_d       = '0;
              state_d     = S_DECRYPT;
            end else begin
              key_write_d = 1'b1;
              state_d     = S_IDLE;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      S_DECRYPT: begin
        tmr_d = tmr_q + TMR_W'(1);
        if (bus.aes_done) begin
          piso_load_d = 1'b1;
          cnt_d       = '0;
          state_d     = S_SHIFT;
        end else if (tmr_q == TMR_LAST) begin
          err_d     = 1'b1;
          aes_clr_d = 1'b1;
          state_d   = S_IDLE;
        end
      end
      S_SHIFT: begin
        if (cnt_q == BLOCK_LAST) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_CLEAR: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are forced low while rst is high so nothing leaks out on the reset cycle itself.
  always_comb begin
    bus.sipo_en   = 1'b0;
    bus.sipo_send = 1'b0;
    bus.instr_o   = '0;
    bus.key_write = 1'b0;
    bus.aes_start = 1'b0;
    bus.aes_clr   = 1'b0;
    bus.piso_load = 1'b0;
    bus.piso_en   = 1'b0;
    bus.sc_en     = 1'b0;
    bus.sc_clear  = 1'b0;
    bus.busy      = 1'b0;
    bus.err       = 1'b0;
    bus.state_o   = '0;
    if (!rst) begin
      bus.sipo_en   = (state_q == S_LOAD) && bus.en;
      bus.sipo_send = sipo_send_q;
      bus.instr_o   = instr_q;
      bus.key_write = key_write_q;
      bus.aes_start = aes_start_q;
      bus.aes_clr   = aes_clr_q || (state_q == S_CLEAR);
      bus.piso_load = piso_load_q;
      bus.piso_en   = (state_q == S_SHIFT);
      bus.sc_en     = (state_q == S_SHIFT);
      bus.sc_clear  = (state_q == S_CLEAR);
      bus.busy      = (state_q != S_IDLE);
      bus.err       = err_q;
      bus.state_o   = state_q;
    end
  end

endmodule

// File: tb/tb_pmu_seq_ctrl.sv
// Directed bench for pmu_seq_ctrl: key load, decrypt, stall, invalid/clear, timeout, reset in SHIFT.
module tb_pmu_seq_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pmu_seq_ctrl_if #(.INSTR_W(4)) bus ();

  pmu_seq_ctrl #(.BLOCK_W(128), .INSTR_W(4), .AES_TIMEOUT(64)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [17:0] outs;
  assign outs = {bus.sipo_en, bus.sipo_send, bus.instr_o, bus.key_write, bus.aes_start,
                 bus.aes_clr, bus.piso_load, bus.piso_en, bus.sc_en, bus.sc_clear,
                 bus.busy, bus.err, bus.state_o};

  // Inputs change just after the rising edge; outputs are sampled on the falling edge.
  task automatic cyc(input logic e, input logic d, input logic done);
    @(posedge clk); #1;
    bus.en = e; bus.data_i = d; bus.aes_done = done;
    @(negedge clk);
  endtask

  task automatic send_instr(input logic [3:0] op);
    for (int i = 3; i >= 0; i--) cyc(1'b1, op[i], 1'b0);
  endtask

  task automatic send_payload(input int n, output int sipo_cnt, output int pulse_cnt);
    sipo_cnt = 0; pulse_cnt = 0;
    for (int i = 0; i < n; i++) begin
      cyc(1'b1, 1'($urandom_range(0, 1)), 1'b0);
      sipo_cnt  += int'(bus.sipo_en);
      pulse_cnt += int'(bus.sipo_send | bus.key_write | bus.aes_start);
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1; rst = 1'b1; bus.en = 1'b0; bus.data_i = 1'b0; bus.aes_done = 1'b0;
    @(negedge clk);
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; bus.en = 1'b1; bus.data_i = 1'b1; bus.aes_done = 1'b1;
    @(negedge clk);
    n_tests++; if (outs !== '0) begin n_fail++; $display("FAIL reset_during: got %0h want 0", outs); end
    @(posedge clk); #1; rst = 1'b0; bus.en = 1'b0; bus.data_i = 1'b0; bus.aes_done = 1'b0;
    @(negedge clk);
    n_tests++; if (outs !== '0) begin n_fail++; $display("FAIL reset_after: got %0h want 0", outs); end
  endtask

  task automatic test_load_key();
    int sc, pc;
    send_instr(4'h1);
    send_payload(128, sc, pc);
    n_tests++; if (sc !== 128) begin n_fail++; $display("FAIL lk_sipo_cnt: got %0d want 128", sc); end
    n_tests++; if (pc !== 0) begin n_fail++; $display("FAIL lk_early_pulse: got %0d want 0", pc); end
    cyc(1'b0, 1'b0, 1'b0);
    n_tests++; if (bus.key_write !== 1'b1) begin n_fail++; $display("FAIL lk_key_write: got %0b want 1", bus.key_write); end
    n_tests++; if (bus.sipo_send !== 1'b1) begin n_fail++; $display("FAIL lk_sipo_send: got %0b want 1", bus.sipo_send); end
    n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL lk_busy: got %0b want 0", bus.busy); end
    n_tests++; if (bus.state_o !== 3'd0) begin n_fail++; $display("FAIL lk_state: got %0d want 0", bus.state_o); end
    n_tests++; if (bus.instr_o !== 4'h1) begin n_fail++; $display("FAIL lk_instr: got %0h want 1", bus.instr_o); end
    n_tests++; if (bus.aes_start !== 1'b0) begin n_fail++; $display("FAIL lk_aes_start: got %0b want 0", bus.aes_start); end
    cyc(1'b0, 1'b0, 1'b0);
    n_tests++; if ({bus.key_write, bus.sipo_send} !== 2'b00) begin n_fail++; $display("FAIL lk_pulse_width: got %0b want 00", {bus.key_write, bus.sipo_send}); end
  endtask

  task automatic test_decrypt();
    int sc, pc, pl, shift, first_pl;
    bit idle;
    send_instr(4'h2);
    send_payload(128, sc, pc);
    n_tests++; if (sc !== 128) begin n_fail++; $display("FAIL dec_sipo_cnt: got %0d want 128", sc); end
    cyc(1'b0, 1'b0, 1'b0);
    n_tests++; if ({bus.aes_start, bus.sipo_send, bus.key_write} !== 3'b110) begin n_fail++; $display("FAIL dec_start: got %0b want 110", {bus.aes_start, bus.sipo_send, bus.key_write}); end
    n_tests++; if (bus.state_o !== 3'd3) begin n_fail++; $display("FAIL dec_state: got %0d want 3", bus.state_o); end
    pl = 0;
    for (int j = 1; j <= 9; j++) begin
      cyc(1'b0, 1'b0, 1'b0);
      pl += int'(bus.piso_load | bus.aes_start);
    end
    n_tests++; if (pl !== 0 || bus.state_o !== 3'd3) begin n_fail++; $display("FAIL dec_wait: got pulses=%0d state=%0d want 0/3", pl, bus.state_o); end
    cyc(1'b0, 1'b0, 1'b1);
    shift = 0; pl = 0; first_pl = 0; idle = 0;
    for (int it = 0; it < 200; it++) begin
      if (it < 100) cyc(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      else          cyc(1'b0, 1'b0, 1'b0);
      if (bus.state_o == 3'd0) begin idle = 1; break; end
      shift += int'(bus.piso_en & bus.sc_en);
      pl    += int'(bus.piso_load);
      if (it == 0) first_pl = int'(bus.piso_load);
    end
    n_tests++; if (idle !== 1'b1) begin n_fail++; $display("FAIL dec_idle_timeout: got 0 want 1"); end
    n_tests++; if (shift !== 128) begin n_fail++; $display("FAIL dec_shift_cnt: got %0d want 128", shift); end
    n_tests++; if (pl !== 1 || first_pl !== 1) begin n_fail++; $display("FAIL dec_piso_load: got cnt=%0d first=%0d want 1/1", pl, first_pl); end
    n_tests++; if ({bus.piso_en, bus.sc_en, bus.busy} !== 3'b000) begin n_fail++; $display("FAIL dec_after_shift: got %0b want 000", {bus.piso_en, bus.sc_en, bus.busy}); end
  endtask

  task automatic test_stall();
    int sc1, pc1, sc2, pc2, bad;
    bit idle;
    send_instr(4'h2);
    send_payload(60, sc1, pc1);
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, 1'($urandom_range(0, 1)), 1'b0);
      bad += int'(bus.sipo_en | bus.sipo_send | (bus.state_o != 3'd2));
    end
    n_tests++; if (bad !== 0) begin n_fail++; $display("FAIL stall_hold: got %0d bad cycles want 0", bad); end
    send_payload(68, sc2, pc2);
    n_tests++; if (sc1 + sc2 !== 128 || pc1 + pc2 !== 0) begin n_fail++; $display("FAIL stall_counts: got sipo=%0d pulses=%0d want 128/0", sc1 + sc2, pc1 + pc2); end
    cyc(1'b0, 1'b0, 1'b0);
    n_tests++; if ({bus.sipo_send, bus.aes_start} !== 2'b11) begin n_fail++; $display("FAIL stall_send: got %0b want 11", {bus.sipo_send, bus.aes_start}); end
    cyc(1'b0, 1'b0, 1'b1);
    idle = 0;
    for (int it = 0; it < 200; it++) begin
      cyc(1'b0, 1'b0, 1'b0);
      if (bus.state_o == 3'd0) begin idle = 1; break; end
    end
    n_tests++; if (idle !== 1'b1) begin n_fail++; $display("FAIL stall_idle_timeout: got 0 want 1"); end
  endtask

  task automatic test_invalid_clear();
    int p;
    n_tests++; if (bus.err !== 1'b0) begin n_fail++; $display("FAIL inv_err_pre: got %0b want 0", bus.err); end
    send_instr(4'hF);
    p = 0;
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b0, 1'b0);
      p += int'(bus.sipo_send | bus.key_write | bus.aes_start | bus.aes_clr | bus.piso_load |
                bus.sc_clear | bus.sipo_en | bus.piso_en | bus.sc_en);
      if (i == 0) begin
        n_tests++; if ({bus.err, bus.busy, bus.state_o} !== 5'b10000) begin n_fail++; $display("FAIL inv_err: got err=%0b busy=%0b state=%0d want 1/0/0", bus.err, bus.busy, bus.state_o); end
      end
    end
    n_tests++; if (p !== 0) begin n_fail++; $display("FAIL inv_pulses: got %0d want 0", p); end
    send_instr(4'h3);
    cyc(1'b0, 1'b0, 1'b0);
    n_tests++; if ({bus.sc_clear, bus.aes_clr, bus.busy, bus.state_o} !== 6'b111101) begin n_fail++; $display("FAIL clr_pulse: got %0b want 111101", {bus.sc_clear, bus.aes_clr, bus.busy, bus.state_o}); end
    cyc(1'b0, 1'b0, 1'b0);
    n_tests++; if ({bus.sc_clear, bus.aes_clr, bus.state_o} !== 5'b00000) begin n_fail++; $display("FAIL clr_end: got %0b want 00000", {bus.sc_clear, bus.aes_clr, bus.state_o}); end
    n_tests++; if (bus.err !== 1'b1) begin n_fail++; $display("FAIL clr_err_sticky: got %0b want 1", bus.err); end
  endtask

  task automatic test_timeout();
    int sc, pc, p;
    do_reset();
    n_tests++; if (bus.err !== 1'b0) begin n_fail++; $display("FAIL to_err_cleared: got %0b want 0", bus.err); end
    send_instr(4'h2);
    send_payload(128, sc, pc);
    cyc(1'b0, 1'b0, 1'b0);
    n_tests++; if (bus.aes_start !== 1'b1) begin n_fail++; $display("FAIL to_start: got %0b want 1", bus.aes_start); end
    for (int k = 1; k <= 65; k++) begin
      cyc(1'b0, 1'b0, 1'b0);
      if (k == 63) begin
        n_tests++; if ({bus.state_o, bus.aes_clr, bus.err} !== 5'b01100) begin n_fail++; $display("FAIL to_k63: got %0b want 01100", {bus.state_o, bus.aes_clr, bus.err}); end
      end else if (k == 64) begin
        n_tests++; if ({bus.state_o, bus.aes_clr, bus.err} !== 5'b00011) begin n_fail++; $display("FAIL to_k64: got %0b want 00011", {bus.state_o, bus.aes_clr, bus.err}); end
      end else if (k == 65) begin
        n_tests++; if ({bus.aes_clr, bus.err} !== 2'b01) begin n_fail++; $display("FAIL to_k65: got %0b want 01", {bus.aes_clr, bus.err}); end
      end
    end
    p = 0;
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b0, 1'b1);
      p += int'(bus.piso_load | bus.busy);
    end
    n_tests++; if (p !== 0 || bus.err !== 1'b1) begin n_fail++; $display("FAIL to_done_ignored: got pulses=%0d err=%0b want 0/1", p, bus.err); end
  endtask

  task automatic test_rst_in_shift();
    int sc, pc, sh;
    send_instr(4'h2);
    send_payload(128, sc, pc);
    cyc(1'b0, 1'b0, 1'b1);
    n_tests++; if (bus.aes_start !== 1'b1) begin n_fail++; $display("FAIL rs_start: got %0b want 1", bus.aes_start); end
    sh = 0;
    for (int s = 0; s < 40; s++) begin
      cyc(1'b0, 1'b0, 1'b0);
      sh += int'(bus.piso_en);
    end
    n_tests++; if (sh !== 40) begin n_fail++; $display("FAIL rs_shift40: got %0d want 40", sh); end
    @(posedge clk); #1; rst = 1'b1;
    @(negedge clk);
    n_tests++; if (outs !== '0) begin n_fail++; $display("FAIL rs_reset_cycle: got %0h want 0", outs); end
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    n_tests++; if (outs !== '0) begin n_fail++; $display("FAIL rs_after: got %0h want 0", outs); end
    cyc(1'b0, 1'b0, 1'b0);
    n_tests++; if (outs !== '0) begin n_fail++; $display("FAIL rs_quiet: got %0h want 0", outs); end
    send_instr(4'h1);
    send_payload(128, sc, pc);
    cyc(1'b0, 1'b0, 1'b0);
    n_tests++; if ({bus.key_write, bus.sipo_send, bus.err, bus.state_o} !== 6'b110000) begin n_fail++; $display("FAIL rs_reload: got %0b want 110000", {bus.key_write, bus.sipo_send, bus.err, bus.state_o}); end
  endtask

  initial begin
    bus.en = 1'b0; bus.data_i = 1'b0; bus.aes_done = 1'b0;
    test_reset();
    test_load_key();
    test_decrypt();
    test_stall();
    test_invalid_clear();
    test_timeout();
    test_rst_in_shift();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
